ysyx_22050710_mem_arb: RTL and testbench

//   Shares one SRAM-style memory port between instruction fetch (IFU, port 0) and load/store (LSU, port 1).
//   - Accepts one request at a time.
//   - Issues it downstream, waits for the response, then routes it back to the owning requester.
//   - Sits between IFU/EXU and the memory/bus model. Only one transaction is outstanding at any time.

---
 rtl/ysyx_22050710_mem_arb_pkg.sv | 29 ++
 rtl/ysyx_22050710_rr_pick2.sv | 26 ++
 rtl/ysyx_22050710_mem_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_ysyx_22050710_mem_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_mem_arb_pkg
//   Shared types for the IFU/LSU memory arbiter: FSM state encoding, request
//   owner encoding and the sizing helper for the optional WAIT timeout counter
//   (enabled by YSYX_22050710_ARB_TIMEOUT_EN).
// ----------------------------------------------------------------------------
package ysyx_22050710_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_CNT_MIN_W = 8;

    // Timeout counter is at least 8 bits, wider only if the limit needs it.
    function automatic int unsigned timeout_cnt_w(input int unsigned limit);
        int unsigned need;
        need = $clog2(limit + 1);
        return (need > TIMEOUT_CNT_MIN_W) ? need : TIMEOUT_CNT_MIN_W;
    endfunction

endpackage

// File: rtl/ysyx_22050710_rr_pick2.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_rr_pick2
//   Two-way round-robin picker (combinational).
//   i_req        : request vector, bit 0 = IFU, bit 1 = LSU
//   i_last_grant : owner granted most recently
//   o_gnt        : one-hot grant (all zero when nothing requests)
// ----------------------------------------------------------------------------
module ysyx_22050710_rr_pick2
    import ysyx_22050710_mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_e     i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_req == 2'b11) begin
            // Contention: the port that did not win last time goes first.
            o_gnt = (i_last_grant == OWNER_IF) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/ysyx_22050710_mem_arb.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_mem_arb
//   Shares one SRAM-style memory port between IFU (port 0, read only) and
//   LSU (port 1, load/store). One transaction outstanding at a time:
//   IDLE (arbitrate, latch) -> ISSUE (drive mem request) -> WAIT (await resp).
//   Ports:
//     i_clk / i_rst                 clock, async active-high reset
//     i_if_* / o_if_*               IFU request handshake and response
//     i_ls_* / o_ls_*               LSU request handshake and response
//     o_mem_* / i_mem_*             downstream request (latched) and response
//     o_busy                        FSM not in IDLE
//   Build option: YSYX_22050710_ARB_TIMEOUT_EN adds a WAIT watchdog that
//   answers the owner with resp_err=1 after TIMEOUT cycles; without it the
//   error outputs are constant 0 and WAIT lasts until a response arrives.
// ----------------------------------------------------------------------------
module ysyx_22050710_mem_arb
    import ysyx_22050710_mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_if_req_valid,
    output logic            o_if_req_ready,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_resp_valid,
    output logic [DW-1:0]   o_if_rdata,
    output logic            o_if_resp_err,

    input  logic            i_ls_req_valid,
    output logic            o_ls_req_ready,
    input  logic [AW-1:0]   i_ls_addr,
    input  logic            i_ls_wen,
    input  logic [DW-1:0]   i_ls_wdata,
    input  logic [DW/8-1:0] i_ls_wmask,
    output logic            o_ls_resp_valid,
    output logic [DW-1:0]   o_ls_rdata,
    output logic            o_ls_resp_err,

    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_wen,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wmask,
    input  logic            i_mem_resp_valid,
    input  logic [DW-1:0]   i_mem_rdata,

    output logic            o_busy
);

    localparam int unsigned MW = DW / 8;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    owner_e          last_grant_q, last_grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic            if_resp_valid_q, if_resp_valid_d;
    logic            ls_resp_valid_q, ls_resp_valid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;

    logic [1:0]      gnt;
    logic            deliver;
    logic            deliver_err;
    logic [DW-1:0]   deliver_data;

`ifdef YSYX_22050710_ARB_TIMEOUT_EN
    localparam int unsigned CW = timeout_cnt_w(TIMEOUT);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            if_resp_err_q, if_resp_err_d;
    logic            ls_resp_err_q, ls_resp_err_d;
`endif

    ysyx_22050710_rr_pick2 u_pick (
        .i_req        ({i_ls_req_valid, i_if_req_valid}),
        .i_last_grant (last_grant_q),
        .o_gnt        (gnt)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        mem_req_valid_d = mem_req_valid_q;
        if_resp_valid_d = 1'b0;
        ls_resp_valid_d = 1'b0;
        if_rdata_d      = if_rdata_q;
        ls_rdata_d      = ls_rdata_q;
        o_if_req_ready  = 1'b0;
        o_ls_req_ready  = 1'b0;
        deliver         = 1'b0;
        deliver_err     = 1'b0;
        deliver_data    = '0;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
        cnt_d           = cnt_q;
        if_resp_err_d   = if_resp_err_q;
        ls_resp_err_d   = ls_resp_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (gnt[1]) begin
                    o_ls_req_ready  = 1'b1;
                    owner_d         = OWNER_LS;
                    last_grant_d    = OWNER_LS;
                    addr_d          = i_ls_addr;
                    wen_d           = i_ls_wen;
                    wdata_d         = i_ls_wdata;
                    wmask_d         = i_ls_wmask;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end else if (gnt[0]) begin
                    o_if_req_ready  = 1'b1;
                    owner_d         = OWNER_IF;
                    last_grant_d    = OWNER_IF;
                    addr_d          = i_if_addr;
                    wen_d           = 1'b0;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_WAIT;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (i_mem_resp_valid) begin
                    // A real response beats a timeout landing in the same cycle.
                    deliver      = 1'b1;
                    deliver_data = wen_q ? '0 : i_mem_rdata;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
                end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
                    deliver     = 1'b1;
                    deliver_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            state_d = ST_IDLE;
            if (owner_q == OWNER_IF) begin
                if_resp_valid_d = 1'b1;
                if_rdata_d      = deliver_data;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
                if_resp_err_d   = deliver_err;
`endif
            end else begin
                ls_resp_valid_d = 1'b1;
                ls_rdata_d      = deliver_data;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
                ls_resp_err_d   = deliver_err;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWNER_IF;
            last_grant_q    <= OWNER_IF;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            ls_rdata_q      <= '0;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
            cnt_q           <= '0;
            if_resp_err_q   <= 1'b0;
            ls_resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            mem_req_valid_q <= mem_req_valid_d;
            if_resp_valid_q <= if_resp_valid_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            if_rdata_q      <= if_rdata_d;
            ls_rdata_q      <= ls_rdata_d;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
            cnt_q           <= cnt_d;
            if_resp_err_q   <= if_resp_err_d;
            ls_resp_err_q   <= ls_resp_err_d;
`endif
        end
    end

    assign o_if_resp_valid = if_resp_valid_q;
    assign o_if_rdata      = if_rdata_q;
    assign o_ls_resp_valid = ls_resp_valid_q;
    assign o_ls_rdata      = ls_rdata_q;
    assign o_mem_req_valid = mem_req_valid_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_wen       = wen_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wmask     = wmask_q;
    assign o_busy          = (state_q != ST_IDLE);

`ifdef YSYX_22050710_ARB_TIMEOUT_EN
    assign o_if_resp_err   = if_resp_err_q;
    assign o_ls_resp_err   = ls_resp_err_q;
`else
    assign o_if_resp_err   = 1'b0;
    assign o_ls_resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050710_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050710_mem_arb
//   Scenario-driven bench for the IFU/LSU memory arbiter. Expected responses
//   are queued when a transaction is set up; a negedge monitor pops them in
//   order as response pulses appear. Honours YSYX_22050710_ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_ysyx_22050710_mem_arb;

    typedef struct {
        bit          port;   // 0 = IFU, 1 = LSU
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req_valid, o_if_req_ready, o_if_resp_valid, o_if_resp_err;
    logic [31:0] i_if_addr;
    logic [63:0] o_if_rdata;
    logic        i_ls_req_valid, o_ls_req_ready, i_ls_wen, o_ls_resp_valid, o_ls_resp_err;
    logic [31:0] i_ls_addr;
    logic [63:0] i_ls_wdata, o_ls_rdata;
    logic [7:0]  i_ls_wmask;
    logic        o_mem_req_valid, i_mem_req_ready, o_mem_wen, i_mem_resp_valid, o_busy;
    logic [31:0] o_mem_addr;
    logic [63:0] o_mem_wdata, i_mem_rdata;
    logic [7:0]  o_mem_wmask;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        exp_q[$];

    ysyx_22050710_mem_arb #(.AW(32), .DW(64), .TIMEOUT(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_if_req_valid   (i_if_req_valid),
        .o_if_req_ready   (o_if_req_ready),
        .i_if_addr        (i_if_addr),
        .o_if_resp_valid  (o_if_resp_valid),
        .o_if_rdata       (o_if_rdata),
        .o_if_resp_err    (o_if_resp_err),
        .i_ls_req_valid   (i_ls_req_valid),
        .o_ls_req_ready   (o_ls_req_ready),
        .i_ls_addr        (i_ls_addr),
        .i_ls_wen         (i_ls_wen),
        .i_ls_wdata       (i_ls_wdata),
        .i_ls_wmask       (i_ls_wmask),
        .o_ls_resp_valid  (o_ls_resp_valid),
        .o_ls_rdata       (o_ls_rdata),
        .o_ls_resp_err    (o_ls_resp_err),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wen        (o_mem_wen),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_wmask      (o_mem_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_rdata      (i_mem_rdata),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    // Response monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (o_if_resp_valid || o_ls_resp_valid)) begin
            total++;
            if (o_if_resp_valid && o_ls_resp_valid) begin
                bad++;
                $display("FAIL resp_both: if_valid=1 ls_valid=1, required one-hot");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: if_valid=%0b ls_valid=%0b, required no pulse",
                         o_if_resp_valid, o_ls_resp_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.port == 1'b0) begin
                    if ({o_if_resp_valid, o_if_rdata, o_if_resp_err} !== {1'b1, e.rdata, e.err}) begin
                        bad++;
                        $display("FAIL resp_if: valid=%0b rdata=%h err=%0b, required valid=1 rdata=%h err=%0b",
                                 o_if_resp_valid, o_if_rdata, o_if_resp_err, e.rdata, e.err);
                    end
                end else begin
                    if ({o_ls_resp_valid, o_ls_rdata, o_ls_resp_err} !== {1'b1, e.rdata, e.err}) begin
                        bad++;
                        $display("FAIL resp_ls: valid=%0b rdata=%h err=%0b, required valid=1 rdata=%h err=%0b",
                                 o_ls_resp_valid, o_ls_rdata, o_ls_resp_err, e.rdata, e.err);
                    end
                end
            end
        end
    end

    // Memory-side driver: waits for the request, optionally holds ready low
    // while checking the request stays stable, accepts, then responds.
    task automatic mem_serve(input int unsigned ready_lat, input int unsigned resp_lat,
                             input logic [63:0] rdata, input bit drop_if, input bit drop_ls,
                             output logic [31:0] a, output logic w,
                             output logic [63:0] wd, output logic [7:0] wm);
        bit seen;
        seen = 1'b0;
        a = '0; w = 1'b0; wd = '0; wm = '0;
        for (int k = 0; k < 20; k++) begin
            if (o_mem_req_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL mem_req_wait: o_mem_req_valid=0 after 20 cycles, required 1");
            return;
        end
        a = o_mem_addr; w = o_mem_wen; wd = o_mem_wdata; wm = o_mem_wmask;
        if (drop_if) i_if_req_valid = 1'b0;
        if (drop_ls) i_ls_req_valid = 1'b0;
        for (int k = 0; k < int'(ready_lat); k++) begin
            @(posedge clk); #1;
            total++;
            if ({o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask} !== {1'b1, a, w, wd, wm}) begin
                bad++;
                $display("FAIL hold_stable: valid=%0b addr=%h wen=%0b wdata=%h wmask=%h, required valid=1 addr=%h wen=%0b wdata=%h wmask=%h",
                         o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, a, w, wd, wm);
            end
        end
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        repeat (resp_lat) begin
            @(posedge clk); #1;
        end
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = rdata;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_if_req_ready, o_if_resp_valid, o_if_resp_err, o_ls_req_ready, o_ls_resp_valid,
             o_ls_resp_err, o_mem_req_valid, o_mem_wen, o_mem_wmask, o_busy} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: ctrl=%b, required all 0",
                     {o_if_req_ready, o_if_resp_valid, o_if_resp_err, o_ls_req_ready, o_ls_resp_valid,
                      o_ls_resp_err, o_mem_req_valid, o_mem_wen, o_mem_wmask, o_busy});
        end
        total++;
        if ({o_if_rdata, o_ls_rdata, o_mem_wdata, o_mem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_data: if_rdata=%h ls_rdata=%h wdata=%h addr=%h, required 0",
                     o_if_rdata, o_ls_rdata, o_mem_wdata, o_mem_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_if_only();
        logic [31:0] a; logic w; logic [63:0] wd; logic [7:0] wm;
        i_if_req_valid = 1'b1;
        i_if_addr      = 32'h8000_0000;
        @(negedge clk);
        total++;
        if ({o_if_req_ready, o_ls_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL if_only_ready: if=%0b ls=%0b, required if=1 ls=0", o_if_req_ready, o_ls_req_ready);
        end
        exp_q.push_back('{1'b0, 64'h0000_0000_0010_0073, 1'b0});
        mem_serve(0, 3, 64'h0000_0000_0010_0073, 1'b1, 1'b0, a, w, wd, wm);
        total++;
        if ({a, w, wm} !== {32'h8000_0000, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL if_only_fields: addr=%h wen=%0b wmask=%h, required 80000000 0 00", a, w, wm);
        end
        total++;
        if ({o_if_resp_valid, o_if_rdata, o_busy} !== {1'b1, 64'h0000_0000_0010_0073, 1'b0}) begin
            bad++;
            $display("FAIL if_only_latency: valid=%0b rdata=%h busy=%0b, required 1 100073 0",
                     o_if_resp_valid, o_if_rdata, o_busy);
        end
        @(posedge clk); #1;
        total++;
        if ({o_if_resp_valid, o_ls_resp_valid, o_ls_rdata, o_ls_resp_err} !== '0) begin
            bad++;
            $display("FAIL if_only_quiet: if_v=%0b ls_v=%0b ls_rdata=%h ls_err=%0b, required 0",
                     o_if_resp_valid, o_ls_resp_valid, o_ls_rdata, o_ls_resp_err);
        end
    endtask

    // Both ports valid; first_ls selects which side should win given last_grant.
    task automatic test_round_robin(input bit first_ls, input logic [63:0] d0, input logic [63:0] d1);
        logic [31:0] a; logic w; logic [63:0] wd; logic [7:0] wm;
        i_if_req_valid = 1'b1; i_if_addr = 32'h8000_0100;
        i_ls_req_valid = 1'b1; i_ls_addr = 32'h8000_2000;
        i_ls_wen = 1'b0; i_ls_wdata = '0; i_ls_wmask = '0;
        @(negedge clk);
        total++;
        if ({o_if_req_ready, o_ls_req_ready} !== (first_ls ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL rr_ready: if=%0b ls=%0b, required if=%0b ls=%0b",
                     o_if_req_ready, o_ls_req_ready, !first_ls, first_ls);
        end
        exp_q.push_back('{first_ls, d0, 1'b0});
        mem_serve(0, 1, d0, !first_ls, first_ls, a, w, wd, wm);
        total++;
        if (a !== (first_ls ? 32'h8000_2000 : 32'h8000_0100)) begin
            bad++;
            $display("FAIL rr_first_addr: addr=%h, required %h", a, first_ls ? 32'h8000_2000 : 32'h8000_0100);
        end
        // Pending loser must be accepted in the very cycle the pulse shows.
        total++;
        if ((first_ls ? {o_ls_resp_valid, o_if_req_ready} : {o_if_resp_valid, o_ls_req_ready}) !== 2'b11) begin
            bad++;
            $display("FAIL rr_overlap: resp_valid/next_ready=%b, required 11",
                     first_ls ? {o_ls_resp_valid, o_if_req_ready} : {o_if_resp_valid, o_ls_req_ready});
        end
        exp_q.push_back('{!first_ls, d1, 1'b0});
        mem_serve(0, 1, d1, first_ls, !first_ls, a, w, wd, wm);
        total++;
        if (a !== (first_ls ? 32'h8000_0100 : 32'h8000_2000)) begin
            bad++;
            $display("FAIL rr_second_addr: addr=%h, required %h", a, first_ls ? 32'h8000_0100 : 32'h8000_2000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [31:0] a; logic w; logic [63:0] wd; logic [7:0] wm;
        i_ls_req_valid = 1'b1; i_ls_addr = 32'h8000_1000;
        i_ls_wen = 1'b1; i_ls_wdata = 64'h0000_0000_DEAD_BEEF; i_ls_wmask = 8'h0F;
        exp_q.push_back('{1'b1, 64'd0, 1'b0});
        mem_serve(4, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, a, w, wd, wm);
        total++;
        if ({a, w, wd, wm} !== {32'h8000_1000, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F}) begin
            bad++;
            $display("FAIL store_fields: addr=%h wen=%0b wdata=%h wmask=%h, required 80001000 1 deadbeef 0f",
                     a, w, wd, wm);
        end
        total++;
        if ({o_ls_resp_valid, o_ls_rdata, o_if_resp_valid} !== {1'b1, 64'd0, 1'b0}) begin
            bad++;
            $display("FAIL store_resp: ls_v=%0b ls_rdata=%h if_v=%0b, required 1 0 0",
                     o_ls_resp_valid, o_ls_rdata, o_if_resp_valid);
        end
        i_ls_wen = 1'b0; i_ls_wdata = '0; i_ls_wmask = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_stray_resp();
        logic [31:0] a; logic w; logic [63:0] wd; logic [7:0] wm;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b1; i_mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0; i_mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_if_resp_valid, o_ls_resp_valid, o_busy, o_mem_req_valid} !== 4'b0000) begin
                bad++;
                $display("FAIL stray_idle: if_v=%0b ls_v=%0b busy=%0b mem_v=%0b, required 0",
                         o_if_resp_valid, o_ls_resp_valid, o_busy, o_mem_req_valid);
            end
            @(posedge clk); #1;
        end
        i_if_req_valid = 1'b1; i_if_addr = 32'h8000_0200;
        exp_q.push_back('{1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0});
        mem_serve(1, 0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, a, w, wd, wm);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        i_if_req_valid = 1'b1; i_if_addr = 32'h8000_0300;
        @(posedge clk); #1;
        i_if_req_valid  = 1'b0;
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        total++;
        if ({o_busy, o_mem_req_valid} !== 2'b10) begin
            bad++;
            $display("FAIL mid_wait: busy=%0b mem_v=%0b, required busy=1 mem_v=0", o_busy, o_mem_req_valid);
        end
        rst = 1'b1;
        #2;
        total++;
        if ({o_busy, o_mem_addr} !== '0) begin
            bad++;
            $display("FAIL mid_async: busy=%0b addr=%h, required 0", o_busy, o_mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_mem_resp_valid = 1'b1; i_mem_rdata = 64'h5555_5555_5555_5555;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0; i_mem_rdata = '0;
        total++;
        if ({o_if_resp_valid, o_ls_resp_valid, o_busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_late_resp: if_v=%0b ls_v=%0b busy=%0b, required 0",
                     o_if_resp_valid, o_ls_resp_valid, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        i_if_req_valid = 1'b1; i_if_addr = 32'h8000_0400;
        @(posedge clk); #1;
        i_if_req_valid  = 1'b0;
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
`ifdef YSYX_22050710_ARB_TIMEOUT_EN
        exp_q.push_back('{1'b0, 64'd0, 1'b1});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({o_if_resp_valid, o_busy} !== 2'b01) begin
                bad++;
                $display("FAIL timeout_early: cycle=%0d if_v=%0b busy=%0b, required 0 1", k, o_if_resp_valid, o_busy);
            end
        end
        @(posedge clk); #1;
        total++;
        if ({o_if_resp_valid, o_if_resp_err, o_if_rdata, o_busy} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
            bad++;
            $display("FAIL timeout_fire: v=%0b err=%0b rdata=%h busy=%0b, required 1 1 0 0",
                     o_if_resp_valid, o_if_resp_err, o_if_rdata, o_busy);
        end
`else
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if ({o_if_resp_valid, o_if_resp_err, o_busy} !== 3'b001) begin
                bad++;
                $display("FAIL wait_forever: cycle=%0d v=%0b err=%0b busy=%0b, required 0 0 1",
                         k, o_if_resp_valid, o_if_resp_err, o_busy);
            end
        end
        exp_q.push_back('{1'b0, 64'h7777_0000_7777_0000, 1'b0});
        i_mem_resp_valid = 1'b1; i_mem_rdata = 64'h7777_0000_7777_0000;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0; i_mem_rdata = '0;
        total++;
        if ({o_if_resp_valid, o_busy} !== 2'b10) begin
            bad++;
            $display("FAIL wait_release: v=%0b busy=%0b, required 1 0", o_if_resp_valid, o_busy);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        i_if_req_valid = 1'b0; i_if_addr = '0;
        i_ls_req_valid = 1'b0; i_ls_addr = '0; i_ls_wen = 1'b0; i_ls_wdata = '0; i_ls_wmask = '0;
        i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0; i_mem_rdata = '0;

        test_reset();
        test_if_only();
        test_round_robin(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        test_store();
        test_round_robin(1'b0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        test_stray_resp();
        test_reset_mid();
        // Reset restored last_grant to IFU, so contention goes to LSU first.
        test_round_robin(1'b1, 64'h5151_5151_5151_5151, 64'h6262_6262_6262_6262);
        test_timeout();

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses never seen, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
